// File: rtl/find_max_pool_stream_if.sv
// Handshake bundle for the streaming max-pool reducer: beat input side, result output side.
// The DUT uses the slave modport; a driver or bench uses the master modport.
interface find_max_pool_stream_if #(
   parameter int WIDTH     = 8,
   parameter int NUM_IN    = 4,
   parameter int MAX_BEATS = 16,
   parameter int IDX_W     = ((MAX_BEATS * NUM_IN) > 1) ? $clog2(MAX_BEATS * NUM_IN) : 1
);
   logic                    i_valid;
   logic                    o_ready;
   logic [WIDTH*NUM_IN-1:0] i_data_array;
   logic                    i_last;
   logic                    o_valid;
   logic                    i_ready;
   logic [WIDTH-1:0]        o_max;
   logic [IDX_W-1:0]        o_idx;
   logic                    o_trunc;

   modport slave (
      input  i_valid, i_data_array, i_last, i_ready,
      output o_ready, o_valid, o_max, o_idx, o_trunc
   );

   modport master (
      output i_valid, i_data_array, i_last, i_ready,
      input  o_ready, o_valid, o_max, o_idx, o_trunc
   );
endinterface

// File: rtl/find_max_pool_stream.sv
// Streaming max reduction: registered comparator tree over NUM_IN lanes, then a window
// accumulator that tracks the running maximum and its flat argmax index.
module find_max_pool_stream #(
   parameter int WIDTH     = 8,
   parameter int NUM_IN    = 4,
   parameter int SIGNED    = 0,
   parameter int MAX_BEATS = 16,
   parameter int IDX_W     = ((MAX_BEATS * NUM_IN) > 1) ? $clog2(MAX_BEATS * NUM_IN) : 1
) (
   input  logic                  clk,
   input  logic                  rst,
   find_max_pool_stream_if.slave bus
);

   localparam int L      = $clog2(NUM_IN);
   localparam int BEAT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;

   function automatic logic greaterThan(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      if (SIGNED != 0) return $signed(a) > $signed(b);
      else             return a > b;
   endfunction

   logic ready;
   logic accept;
   logic oValid_q, oValid_d;

   // A held, unaccepted result freezes the whole pipeline.
   assign ready       = ~(oValid_q & ~bus.i_ready);
   assign bus.o_ready = ready;
   assign accept      = bus.i_valid & ready;

   logic [BEAT_W-1:0] beatCnt_q, beatCnt_d;
   logic              atLimit;
   logic              inClose;
   logic              inTrunc;

   assign atLimit = (beatCnt_q == BEAT_W'(MAX_BEATS - 1));
   assign inClose = bus.i_last | atLimit;
   assign inTrunc = atLimit & ~bus.i_last;

   always_comb begin
      beatCnt_d = beatCnt_q;
      if (accept) beatCnt_d = inClose ? '0 : beatCnt_q + BEAT_W'(1);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) beatCnt_q <= '0;
      else     beatCnt_q <= beatCnt_d;
   end

   logic [WIDTH-1:0] inVal  [NUM_IN];
   logic [L-1:0]     inLane [NUM_IN];

   for (genvar k = 0; k < NUM_IN; k++) begin : gLaneIn
      assign inVal[k]  = bus.i_data_array[k*WIDTH +: WIDTH];
      assign inLane[k] = L'(k);
   end

   // Each tree stage halves the candidate count; the higher lane wins only when strictly greater.
   for (genvar s = 1; s <= L; s++) begin : gStage
      localparam int N = NUM_IN >> s;

      logic [WIDTH-1:0]  val_q  [N];
      logic [L-1:0]      lane_q [N];
      logic              vld_q;
      logic [BEAT_W-1:0] beat_q;
      logic              cls_q;
      logic              trc_q;

      logic [WIDTH-1:0]  prevVal  [2*N];
      logic [L-1:0]      prevLane [2*N];
      logic              prevVld;
      logic [BEAT_W-1:0] prevBeat;
      logic              prevCls;
      logic              prevTrc;

      if (s == 1) begin : gFirst
         assign prevVal  = inVal;
         assign prevLane = inLane;
         assign prevVld  = accept;
         assign prevBeat = beatCnt_q;
         assign prevCls  = inClose;
         assign prevTrc  = inTrunc;
      end else begin : gNext
         assign prevVal  = gStage[s-1].val_q;
         assign prevLane = gStage[s-1].lane_q;
         assign prevVld  = gStage[s-1].vld_q;
         assign prevBeat = gStage[s-1].beat_q;
         assign prevCls  = gStage[s-1].cls_q;
         assign prevTrc  = gStage[s-1].trc_q;
      end

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q  <= 1'b0;
            beat_q <= '0;
            cls_q  <= 1'b0;
            trc_q  <= 1'b0;
            for (int k = 0; k < N; k++) begin
               val_q[k]  <= '0;
               lane_q[k] <= '0;
            end
         end else if (ready) begin
            vld_q  <= prevVld;
            beat_q <= prevBeat;
            cls_q  <= prevCls;
            trc_q  <= prevTrc;
            for (int k = 0; k < N; k++) begin
               if (greaterThan(prevVal[2*k+1], prevVal[2*k])) begin
                  val_q[k]  <= prevVal[2*k+1];
                  lane_q[k] <= prevLane[2*k+1];
               end else begin
                  val_q[k]  <= prevVal[2*k];
                  lane_q[k] <= prevLane[2*k];
               end
            end
         end
      end
   end

   logic [WIDTH-1:0]  tailVal;
   logic [L-1:0]      tailLane;
   logic              tailVld;
   logic [BEAT_W-1:0] tailBeat;
   logic              tailCls;
   logic              tailTrc;
   logic [IDX_W-1:0]  tailIdx;

   assign tailVal  = gStage[L].val_q[0];
   assign tailLane = gStage[L].lane_q[0];
   assign tailVld  = gStage[L].vld_q;
   assign tailBeat = gStage[L].beat_q;
   assign tailCls  = gStage[L].cls_q;
   assign tailTrc  = gStage[L].trc_q;
   // NUM_IN is a power of two, so beat*NUM_IN + lane is a plain concatenation.
   assign tailIdx  = IDX_W'({tailBeat, tailLane});

   logic [WIDTH-1:0] accVal_q, accVal_d;
   logic [IDX_W-1:0] accIdx_q, accIdx_d;
   logic             first_q, first_d;
   logic [WIDTH-1:0] oMax_q, oMax_d;
   logic [IDX_W-1:0] oIdx_q, oIdx_d;
   logic             oTrunc_q, oTrunc_d;

   // While ready, any held result is being accepted, so o_valid drops unless a window closes now.
   always_comb begin
      accVal_d = accVal_q;
      accIdx_d = accIdx_q;
      first_d  = first_q;
      oValid_d = oValid_q;
      oMax_d   = oMax_q;
      oIdx_d   = oIdx_q;
      oTrunc_d = oTrunc_q;
      if (ready) begin
         oValid_d = 1'b0;
         if (tailVld) begin
            if (first_q || greaterThan(tailVal, accVal_q)) begin
               accVal_d = tailVal;
               accIdx_d = tailIdx;
            end
            first_d = tailCls;
            if (tailCls) begin
               oValid_d = 1'b1;
               oMax_d   = accVal_d;
               oIdx_d   = accIdx_d;
               oTrunc_d = tailTrc;
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         accVal_q <= '0;
         accIdx_q <= '0;
         first_q  <= 1'b1;
         oValid_q <= 1'b0;
         oMax_q   <= '0;
         oIdx_q   <= '0;
         oTrunc_q <= 1'b0;
      end else begin
         accVal_q <= accVal_d;
         accIdx_q <= accIdx_d;
         first_q  <= first_d;
         oValid_q <= oValid_d;
         oMax_q   <= oMax_d;
         oIdx_q   <= oIdx_d;
         oTrunc_q <= oTrunc_d;
      end
   end

   assign bus.o_valid = oValid_q;
   assign bus.o_max   = oMax_q;
   assign bus.o_idx   = oIdx_q;
   assign bus.o_trunc = oTrunc_q;

endmodule

// File: tb/tb_find_max_pool_stream.sv
// Directed bench for find_max_pool_stream: unsigned, signed and MAX_BEATS=4 instances
// driven from one linear sequence with hand-computed expected results.
module tb_find_max_pool_stream;

   logic clk = 1'b0;
   logic rst;
   int   compared   = 0;
   int   mismatched = 0;

   always #5 clk = ~clk;

   find_max_pool_stream_if #(.WIDTH(8), .NUM_IN(4), .MAX_BEATS(16)) busA ();
   find_max_pool_stream_if #(.WIDTH(8), .NUM_IN(4), .MAX_BEATS(16)) busS ();
   find_max_pool_stream_if #(.WIDTH(8), .NUM_IN(4), .MAX_BEATS(4))  busM ();

   find_max_pool_stream #(.WIDTH(8), .NUM_IN(4), .SIGNED(0), .MAX_BEATS(16)) dutA (
      .clk(clk), .rst(rst), .bus(busA));
   find_max_pool_stream #(.WIDTH(8), .NUM_IN(4), .SIGNED(1), .MAX_BEATS(16)) dutS (
      .clk(clk), .rst(rst), .bus(busS));
   find_max_pool_stream #(.WIDTH(8), .NUM_IN(4), .SIGNED(0), .MAX_BEATS(4)) dutM (
      .clk(clk), .rst(rst), .bus(busM));

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   // The unsigned and signed instances always see the same beats.
   task automatic applyStimulus(input logic [31:0] data, input logic valid, input logic last);
      busA.i_data_array = data;
      busA.i_valid      = valid;
      busA.i_last       = last;
      busS.i_data_array = data;
      busS.i_valid      = valid;
      busS.i_last       = last;
   endtask

   task automatic applyStimulusM(input logic [31:0] data, input logic valid, input logic last);
      busM.i_data_array = data;
      busM.i_valid      = valid;
      busM.i_last       = last;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "[TB] bench did not finish");
   end

   initial begin
      rst = 1'b1;
      applyStimulus(32'h0, 1'b0, 1'b0);
      applyStimulusM(32'h0, 1'b0, 1'b0);
      busA.i_ready = 1'b1;
      busS.i_ready = 1'b1;
      busM.i_ready = 1'b1;
      tick;
      tick;
      checkOutput("reset o_valid", busA.o_valid, 0);
      checkOutput("reset o_max", busA.o_max, 0);
      checkOutput("reset o_idx", busA.o_idx, 0);
      checkOutput("reset o_trunc", busA.o_trunc, 0);
      checkOutput("reset o_ready", busA.o_ready, 1);
      rst = 1'b0;
      tick;

      $display("[TB] single-beat window");
      applyStimulus(32'h01090903, 1'b1, 1'b1);
      tick;
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("t1 latency1", busA.o_valid, 0);
      tick;
      checkOutput("t1 latency2", busA.o_valid, 0);
      tick;
      checkOutput("t1 o_valid", busA.o_valid, 1);
      checkOutput("t1 o_max", busA.o_max, 8'h09);
      checkOutput("t1 o_idx", busA.o_idx, 1);
      checkOutput("t1 o_trunc", busA.o_trunc, 0);
      checkOutput("t1 signed o_max", busS.o_max, 8'h09);
      checkOutput("t1 signed o_idx", busS.o_idx, 1);
      tick;
      checkOutput("t1 valid drop", busA.o_valid, 0);

      $display("[TB] three-beat window with a bubble");
      applyStimulus(32'h04050201, 1'b1, 1'b0);
      tick;
      applyStimulus(32'h0C07030C, 1'b1, 1'b0);
      tick;
      applyStimulus(32'h0, 1'b0, 1'b0);
      tick;
      applyStimulus(32'h0C020100, 1'b1, 1'b1);
      tick;
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("t2 early valid1", busA.o_valid, 0);
      tick;
      checkOutput("t2 early valid2", busA.o_valid, 0);
      tick;
      checkOutput("t2 o_valid", busA.o_valid, 1);
      checkOutput("t2 o_max", busA.o_max, 8'h0C);
      checkOutput("t2 o_idx", busA.o_idx, 4);
      checkOutput("t2 o_trunc", busA.o_trunc, 0);
      checkOutput("t2 signed o_idx", busS.o_idx, 4);
      tick;
      checkOutput("t2 single result", busA.o_valid, 0);

      $display("[TB] signed versus unsigned compare");
      applyStimulus(32'h7F0280FF, 1'b1, 1'b1);
      tick;
      applyStimulus(32'h0, 1'b0, 1'b0);
      tick;
      tick;
      checkOutput("t3 unsigned o_max", busA.o_max, 8'hFF);
      checkOutput("t3 unsigned o_idx", busA.o_idx, 0);
      checkOutput("t3 signed o_valid", busS.o_valid, 1);
      checkOutput("t3 signed o_max", busS.o_max, 8'h7F);
      checkOutput("t3 signed o_idx", busS.o_idx, 3);
      tick;

      $display("[TB] all lanes equal");
      applyStimulus(32'h66666666, 1'b1, 1'b1);
      tick;
      applyStimulus(32'h0, 1'b0, 1'b0);
      tick;
      tick;
      checkOutput("eq o_max", busA.o_max, 8'h66);
      checkOutput("eq o_idx", busA.o_idx, 0);
      tick;

      $display("[TB] forced close at MAX_BEATS=4");
      applyStimulusM(32'h281E140A, 1'b1, 1'b0);
      tick;
      applyStimulusM(32'h01010132, 1'b1, 1'b0);
      tick;
      applyStimulusM(32'h02020202, 1'b1, 1'b0);
      tick;
      applyStimulusM(32'h013C0101, 1'b1, 1'b0);
      tick;
      applyStimulusM(32'h00070705, 1'b1, 1'b0);
      tick;
      checkOutput("t4 before close", busM.o_valid, 0);
      applyStimulusM(32'h07070707, 1'b1, 1'b1);
      tick;
      checkOutput("t4 r1 o_valid", busM.o_valid, 1);
      checkOutput("t4 r1 o_max", busM.o_max, 8'h3C);
      checkOutput("t4 r1 o_idx", busM.o_idx, 14);
      checkOutput("t4 r1 o_trunc", busM.o_trunc, 1);
      applyStimulusM(32'h0, 1'b0, 1'b0);
      tick;
      checkOutput("t4 gap", busM.o_valid, 0);
      tick;
      checkOutput("t4 r2 o_valid", busM.o_valid, 1);
      checkOutput("t4 r2 o_max", busM.o_max, 8'h07);
      checkOutput("t4 r2 o_idx", busM.o_idx, 1);
      checkOutput("t4 r2 o_trunc", busM.o_trunc, 0);
      tick;

      $display("[TB] backpressure on back-to-back windows");
      busA.i_ready = 1'b0;
      applyStimulus(32'h00001100, 1'b1, 1'b1);
      tick;
      checkOutput("t5 ready before result", busA.o_ready, 1);
      applyStimulus(32'h22000000, 1'b1, 1'b1);
      tick;
      applyStimulus(32'h00330000, 1'b1, 1'b1);
      tick;
      checkOutput("t5 first o_valid", busA.o_valid, 1);
      checkOutput("t5 first o_ready", busA.o_ready, 0);
      applyStimulus(32'h00000044, 1'b1, 1'b1);
      for (int i = 0; i < 5; i++) begin
         tick;
         checkOutput("t5 stall o_ready", busA.o_ready, 0);
         checkOutput("t5 stall o_max", busA.o_max, 8'h11);
         checkOutput("t5 stall o_idx", busA.o_idx, 1);
      end
      busA.i_ready = 1'b1;
      tick;
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("t5 w1 o_valid", busA.o_valid, 1);
      checkOutput("t5 w1 o_max", busA.o_max, 8'h22);
      checkOutput("t5 w1 o_idx", busA.o_idx, 3);
      tick;
      checkOutput("t5 w2 o_max", busA.o_max, 8'h33);
      checkOutput("t5 w2 o_idx", busA.o_idx, 2);
      tick;
      checkOutput("t5 w3 o_valid", busA.o_valid, 1);
      checkOutput("t5 w3 o_max", busA.o_max, 8'h44);
      checkOutput("t5 w3 o_idx", busA.o_idx, 0);
      tick;
      checkOutput("t5 drained", busA.o_valid, 0);

      $display("[TB] asynchronous reset mid-window");
      busA.i_ready = 1'b0;
      applyStimulus(32'h00000055, 1'b1, 1'b1);
      tick;
      applyStimulus(32'h000000F0, 1'b1, 1'b0);
      tick;
      applyStimulus(32'h0000F000, 1'b1, 1'b0);
      tick;
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("t6 held o_max", busA.o_max, 8'h55);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("t6 rst o_valid", busA.o_valid, 0);
      checkOutput("t6 rst o_max", busA.o_max, 0);
      checkOutput("t6 rst o_idx", busA.o_idx, 0);
      checkOutput("t6 rst o_ready", busA.o_ready, 1);
      busA.i_ready = 1'b1;
      tick;
      rst = 1'b0;
      applyStimulus(32'h00100000, 1'b1, 1'b0);
      tick;
      applyStimulus(32'h00002000, 1'b1, 1'b1);
      tick;
      applyStimulus(32'h0, 1'b0, 1'b0);
      checkOutput("t6 early valid1", busA.o_valid, 0);
      tick;
      checkOutput("t6 early valid2", busA.o_valid, 0);
      tick;
      checkOutput("t6 o_valid", busA.o_valid, 1);
      checkOutput("t6 o_max", busA.o_max, 8'h20);
      checkOutput("t6 o_idx", busA.o_idx, 5);
      checkOutput("t6 o_trunc", busA.o_trunc, 0);
      tick;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/find_max_pool_stream.md
Name: find_max_pool_stream

Overview:
- Streaming, pipelined max-reduction unit for the pooling path.
- Accepts NUM_IN lanes of WIDTH-bit data per beat and reduces them through a registered comparator tree.
- Accumulates the running maximum across a variable-length window of beats, delimited by i_last.
- Emits the window maximum and its flat argmax index over a valid/ready handshake; supports signed and unsigned compare.

Parameters:
- WIDTH, 8, bits per data element.
- NUM_IN, 4, lanes per beat; power of two, >= 2.
- SIGNED, 0, 1 = two's-complement compare, 0 = unsigned compare.
- MAX_BEATS, 16, maximum beats per window; >= 1.
- IDX_W, $clog2(MAX_BEATS*NUM_IN) (minimum 1), width of the argmax index.

Ports:
- clk, input, 1, clock.
- rst, input, 1, asynchronous active-high reset.
- i_valid, input, 1, input beat valid.
- o_ready, output, 1, block can accept a beat.
- i_data_array, input, WIDTH*NUM_IN, lane k at bits [k*WIDTH +: WIDTH].
- i_last, input, 1, final beat of the window.
- o_valid, output, 1, result valid.
- i_ready, input, 1, downstream accepts the result.
- o_max, output, WIDTH, window maximum.
- o_idx, output, IDX_W, argmax index = beat_number*NUM_IN + lane.
- o_trunc, output, 1, window was force-closed at MAX_BEATS.

Behaviour:
- Single clock domain, clk. Reset is asynchronous and active-high on rst.
- Reset values:
  - o_valid = 0, o_max = 0, o_idx = 0, o_trunc = 0.
  - All pipeline valid bits = 0; beat counter = 0; accumulator "first" flag = 1.
  - o_ready = 1 as soon as rst deasserts.
- Global stall: o_ready = ~(o_valid & ~i_ready).
  - Every pipeline register, the beat counter and the accumulator advance only when o_ready = 1.
  - When o_ready = 0, all state holds; a beat presented with i_valid is not consumed.
- Beat accepted when i_valid & o_ready. Per accepted beat:
  - Tag with beat number b (0..MAX_BEATS-1) and close flag = i_last | (b == MAX_BEATS-1).
  - trunc flag = (b == MAX_BEATS-1) & ~i_last.
  - Counter returns to 0 after a close beat, else increments.
- Comparator tree:
  - L = log2(NUM_IN) stages, each registered.
  - Each stage pairs adjacent candidates (value, lane index) and keeps the larger.
  - Compare is strict greater-than: on a tie the lower lane index wins.
  - The signed or unsigned compare is selected by SIGNED.
  - Valid, b, close and trunc tags travel alongside the data.
- Accumulator stage (one register stage after the tree):
  - If first = 1 or the beat max is strictly greater than acc_val: load acc_val and acc_idx = b*NUM_IN + lane.
  - Otherwise keep acc_val and acc_idx. Ties keep the earlier (lower) index.
  - On a close beat: o_max/o_idx = the updated accumulator, o_trunc = trunc tag, o_valid = 1, first = 1.
  - Otherwise first = 0.
- Latency: last beat accepted at cycle t produces o_valid = 1 at cycle t + L + 1, given no stall.
- Throughput: one beat per cycle. Single-beat windows back-to-back give one result per cycle while i_ready = 1.
- Output handshake:
  - o_valid, o_max, o_idx and o_trunc hold stable until i_valid-independent acceptance, o_valid & i_ready.
  - o_valid clears on the accepting cycle unless a new result lands in that same cycle.
  - Acceptance and a new result in the same cycle: the new result loads and o_valid stays 1.
- Boundaries:
  - MAX_BEATS = 1: every beat closes. o_trunc = 1 iff i_last = 0.
  - Bubbles (i_valid = 0) inside a window are allowed. The counter and accumulator only change on valid beats.
  - rst mid-window or while a result is held: the partial window and any held result are discarded. The next accepted beat starts a new window at b = 0.
  - All lanes equal: o_idx = the index of lane 0 of the first beat in the window.

Test Plan:
- Single-beat window, WIDTH=8, NUM_IN=4, SIGNED=0, i_data_array lanes {3,9,9,1} (lane0..3), i_last=1 → after L+1 = 3 cycles: o_max = 9, o_idx = 1, o_trunc = 0.
- Three-beat window with beat maxima 5@lane2, 12@lane0, 12@lane3 → o_max = 12, o_idx = 4, o_valid exactly once.
- SIGNED=1, lanes {0xFF, 0x80, 0x02, 0x7F} with i_last → o_max = 0x7F, o_idx = 3. Same stimulus with SIGNED=0 → o_max = 0xFF, o_idx = 0.
- MAX_BEATS=4, six beats with i_last only on beat 6 →
  - First result after beat 4 with o_trunc = 1.
  - Second result covers beats 5-6 with o_trunc = 0 and indices restarting at 0.
- Back-to-back single-beat windows with i_ready held 0 for 5 cycles →
  - o_ready = 0 while o_valid = 1.
  - Result stable; no beat lost.
  - After i_ready = 1, results emerge in order, one per cycle.
- rst asserted asynchronously after beat 2 of a 4-beat window → outputs clear immediately; the next window yields a result computed only from post-reset beats, with o_idx counted from 0.
